// File: rtl/alu16_arith_logic_core.sv
`default_nettype none
// ============================================================================
// Module   : alu16_arith_logic_core
// Purpose  : Registered 16-bit ALU execute stage (arithmetic, logic, reserved
//            shift class). Optional divider enabled by macro ALU_DIV_EN.
// Revision : 1.0 - initial release
// ============================================================================
module alu16_arith_logic_core (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] packed_in,
    input  logic [4:0]  selection_lines,
    output logic [31:0] packed_out
);

    localparam logic [1:0] c_cls_arith = 2'b00;
    localparam logic [1:0] c_cls_logic = 2'b01;

    localparam logic [2:0] c_op_add = 3'b000;
    localparam logic [2:0] c_op_sub = 3'b001;
    localparam logic [2:0] c_op_mul = 3'b010;
    localparam logic [2:0] c_op_div = 3'b011;
    localparam logic [2:0] c_op_inc = 3'b100;
    localparam logic [2:0] c_op_dec = 3'b101;
    localparam logic [2:0] c_op_neg = 3'b110;
    localparam logic [2:0] c_op_cmp = 3'b111;

    localparam logic [1:0] c_lop_and = 2'b00;
    localparam logic [1:0] c_lop_or  = 2'b01;
    localparam logic [1:0] c_lop_xor = 2'b10;
    localparam logic [1:0] c_lop_not = 2'b11;

    logic [15:0] w_a;
    logic [15:0] w_b;
    logic [1:0]  w_cls;
    logic [2:0]  w_op;
    logic [31:0] w_arith;
    logic [31:0] w_logic;
    logic [31:0] w_result;
    logic [31:0] r_out;

    assign w_a   = packed_in[15:0];
    assign w_b   = packed_in[31:16];
    assign w_cls = selection_lines[4:3];
    assign w_op  = selection_lines[2:0];

    // 17-bit add/sub leaves carry/borrow in bit 16 directly.
    always_comb begin
        w_arith = 32'h0;
        case (w_op)
            c_op_add: w_arith[16:0] = {1'b0, w_a} + {1'b0, w_b};
            c_op_sub: w_arith[16:0] = {1'b0, w_a} - {1'b0, w_b};
            c_op_mul: w_arith       = {16'h0, w_a} * {16'h0, w_b};
            c_op_div: begin
`ifdef ALU_DIV_EN
                if (w_b == 16'h0) begin
                    w_arith = {w_a, 16'hFFFF};
                end else begin
                    w_arith = {w_a % w_b, w_a / w_b};
                end
`else
                w_arith = 32'h0;
`endif
            end
            c_op_inc: w_arith[16:0] = {1'b0, w_a} + 17'd1;
            c_op_dec: w_arith[16:0] = {1'b0, w_a} - 17'd1;
            c_op_neg: w_arith[15:0] = (~w_a) + 16'd1;
            c_op_cmp: w_arith[2:0]  = {(w_a > w_b), (w_a < w_b), (w_a == w_b)};
            default:  w_arith       = 32'h0;
        endcase
    end

    // Logic unit decodes only opcode[1:0]; opcode[2] aliases onto the same ops.
    always_comb begin
        w_logic = 32'h0;
        case (w_op[1:0])
            c_lop_and: w_logic[15:0] = w_a & w_b;
            c_lop_or:  w_logic[15:0] = w_a | w_b;
            c_lop_xor: w_logic[15:0] = w_a ^ w_b;
            c_lop_not: w_logic[15:0] = ~w_a;
            default:   w_logic       = 32'h0;
        endcase
    end

    always_comb begin
        w_result = 32'h0;
        case (w_cls)
            c_cls_arith: w_result = w_arith;
            c_cls_logic: w_result = w_logic;
            default:     w_result = 32'h0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out <= 32'h0;
        end else begin
            r_out <= w_result;
        end
    end

    assign packed_out = r_out;

endmodule
`default_nettype wire

// File: tb/tb_alu16_arith_logic_core.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu16_arith_logic_core
// Purpose  : Directed self-checking bench for alu16_arith_logic_core.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu16_arith_logic_core;

    logic        clk;
    logic        rst;
    logic [31:0] packed_in;
    logic [4:0]  selection_lines;
    logic [31:0] packed_out;

    int n_checks;
    int n_fail;

    alu16_arith_logic_core dut (
        .clk             (clk),
        .rst             (rst),
        .packed_in       (packed_in),
        .selection_lines (selection_lines),
        .packed_out      (packed_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply inputs away from the active edge, then sample just after it.
    task automatic step(input logic [4:0] sel, input logic [31:0] pin);
        @(negedge clk);
        selection_lines = sel;
        packed_in       = pin;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(5'b00_010, 32'hFFFF_FFFF);
        n_checks++;
        if (packed_out !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_edge1 actual=%h required=%h", packed_out, 32'h0);
        end
        step(5'b01_001, 32'h1234_5678);
        n_checks++;
        if (packed_out !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_edge2 actual=%h required=%h", packed_out, 32'h0);
        end
    endtask

    task automatic test_latency();
        @(negedge clk);
        rst             = 1'b0;
        selection_lines = 5'b00_000;
        packed_in       = 32'h0001_FFFF;
        #1;
        n_checks++;
        if (packed_out !== 32'h0) begin
            n_fail++;
            $display("FAIL latency_pre_edge actual=%h required=%h", packed_out, 32'h0);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (packed_out !== 32'h0001_0000) begin
            n_fail++;
            $display("FAIL latency_add_carry actual=%h required=%h", packed_out, 32'h0001_0000);
        end
    endtask

    task automatic test_arith();
        logic [4:0]  sel [10];
        logic [31:0] pin [10];
        logic [31:0] exp [10];
        sel[0] = 5'b00_001; pin[0] = 32'h0005_0003; exp[0] = 32'h0001_FFFE; // 3-5 borrow
        sel[1] = 5'b00_010; pin[1] = 32'hFFFF_FFFF; exp[1] = 32'hFFFE_0001;
        sel[2] = 5'b00_110; pin[2] = 32'h0000_0001; exp[2] = 32'h0000_FFFF;
        sel[3] = 5'b00_111; pin[3] = 32'h0009_0007; exp[3] = 32'h0000_0002;
        sel[4] = 5'b00_111; pin[4] = 32'h0005_0005; exp[4] = 32'h0000_0001;
        sel[5] = 5'b00_111; pin[5] = 32'h0007_0009; exp[5] = 32'h0000_0004;
        sel[6] = 5'b00_100; pin[6] = 32'h1234_FFFF; exp[6] = 32'h0001_0000;
        sel[7] = 5'b00_101; pin[7] = 32'h1234_0000; exp[7] = 32'h0001_FFFF;
        sel[8] = 5'b00_110; pin[8] = 32'h0000_8000; exp[8] = 32'h0000_8000;
        sel[9] = 5'b00_000; pin[9] = 32'h1111_1234; exp[9] = 32'h0000_2345;
        for (int i = 0; i < 10; i++) begin
            step(sel[i], pin[i]);
            n_checks++;
            if (packed_out !== exp[i]) begin
                n_fail++;
                $display("FAIL arith_%0d sel=%b in=%h actual=%h required=%h",
                         i, sel[i], pin[i], packed_out, exp[i]);
            end
        end
    endtask

    task automatic test_div();
        logic [31:0] exp0;
        logic [31:0] exp1;
`ifdef ALU_DIV_EN
        exp0 = 32'h0002_000E;
        exp1 = 32'h0005_FFFF;
`else
        exp0 = 32'h0;
        exp1 = 32'h0;
`endif
        step(5'b00_011, 32'h0007_0064);
        n_checks++;
        if (packed_out !== exp0) begin
            n_fail++;
            $display("FAIL div_100_by_7 actual=%h required=%h", packed_out, exp0);
        end
        step(5'b00_011, 32'h0000_0005);
        n_checks++;
        if (packed_out !== exp1) begin
            n_fail++;
            $display("FAIL div_by_zero actual=%h required=%h", packed_out, exp1);
        end
    endtask

    task automatic test_logic();
        logic [31:0] exp [8];
        exp[0] = 32'h0000_00F0;
        exp[1] = 32'h0000_FFF0;
        exp[2] = 32'h0000_FF00;
        exp[3] = 32'h0000_0F0F;
        exp[4] = 32'h0000_00F0;
        exp[5] = 32'h0000_FFF0;
        exp[6] = 32'h0000_FF00;
        exp[7] = 32'h0000_0F0F;
        for (int i = 0; i < 8; i++) begin
            step({2'b01, 3'(i)}, 32'h0FF0_F0F0);
            n_checks++;
            if (packed_out !== exp[i]) begin
                n_fail++;
                $display("FAIL logic_op%0d actual=%h required=%h", i, packed_out, exp[i]);
            end
        end
    endtask

    task automatic test_mux();
        logic [4:0] sel [4];
        sel[0] = 5'b10_000;
        sel[1] = 5'b10_111;
        sel[2] = 5'b11_010;
        sel[3] = 5'b11_101;
        for (int i = 0; i < 4; i++) begin
            step(5'b01_001, 32'h5A5A_A5A5);
            step(sel[i], 32'hFFFF_FFFF);
            n_checks++;
            if (packed_out !== 32'h0) begin
                n_fail++;
                $display("FAIL mux_zero sel=%b actual=%h required=%h", sel[i], packed_out, 32'h0);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [4:0]  sel [5];
        logic [31:0] pin [5];
        logic [31:0] exp [5];
        sel[0] = 5'b00_000; pin[0] = 32'h0002_0003; exp[0] = 32'h0000_0005;
        sel[1] = 5'b01_010; pin[1] = 32'h00FF_0F0F; exp[1] = 32'h0000_0FF0;
        sel[2] = 5'b00_010; pin[2] = 32'h0010_0100; exp[2] = 32'h0000_1000;
        sel[3] = 5'b00_101; pin[3] = 32'h0000_0010; exp[3] = 32'h0000_000F;
        sel[4] = 5'b01_011; pin[4] = 32'h0000_1234; exp[4] = 32'h0000_EDCB;
        for (int i = 0; i < 5; i++) begin
            step(sel[i], pin[i]);
            n_checks++;
            if (packed_out !== exp[i]) begin
                n_fail++;
                $display("FAIL b2b_%0d actual=%h required=%h", i, packed_out, exp[i]);
            end
        end
        // One-edge reset mid-stream, then resume with the held inputs.
        @(negedge clk);
        rst = 1'b1;
        selection_lines = 5'b00_001;
        packed_in       = 32'h0001_0009;
        @(posedge clk);
        #1;
        n_checks++;
        if (packed_out !== 32'h0) begin
            n_fail++;
            $display("FAIL midstream_reset actual=%h required=%h", packed_out, 32'h0);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        n_checks++;
        if (packed_out !== 32'h0000_0008) begin
            n_fail++;
            $display("FAIL resume_after_reset actual=%h required=%h", packed_out, 32'h0000_0008);
        end
    endtask

    initial begin
        n_checks        = 0;
        n_fail          = 0;
        rst             = 1'b1;
        packed_in       = 32'h0;
        selection_lines = 5'h0;
        test_reset();
        test_latency();
        test_arith();
        test_div();
        test_logic();
        test_mux();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu16_arith_logic_core.md
Name: alu16_arith_logic_core

Overview:
- Registered 16-bit ALU core: two 16-bit operands packed into one 32-bit input word, 5-bit selection (2-bit class, 3-bit opcode), 32-bit registered result.
- Contains an arithmetic unit, a logic unit and a degenerate 3-to-1 result mux.
- Class 2 (shift) is reserved and returns zero in this block.
- Sits as the datapath execute stage; output updates one clock after inputs are sampled.

Parameters:
- none; operand width fixed at 16, result width fixed at 32.

Ports:
- clk  input  1  single clock, rising-edge active.
- rst  input  1  reset; synchronous, active-high.
- packed_in  input  32  operand A = [15:0], operand B = [31:16].
- selection_lines  input  5  [4:3] class code, [2:0] opcode.
- packed_out  output  32  registered result.

Behaviour:
- Interface (already decided): one clock (clk); reset rst is synchronous and active-high.
- Reset: on a rising clk edge with rst=1, packed_out <= 0. Reset has priority over everything.
- Reset mid-operation discards the pending result. The first valid result appears on the first rising edge with rst=0.
- Latency: combinational result is registered on every rising clk edge with rst=0. No handshake; a new operation is accepted every cycle, so throughput is 1 per cycle.
- All arithmetic is unsigned unless stated otherwise. Unused result bits are 0.
- Class code:
  - 00: arithmetic.
  - 01: logic.
  - 10: reserved (shift), result 0.
  - 11: degenerate mux input, result 0.
- Arithmetic opcodes:
  - 000 ADD: [16:0] = A+B, with bit 16 = carry.
  - 001 SUB: [15:0] = A-B mod 2^16; bit 16 = borrow (1 iff A<B).
  - 010 MUL: [31:0] = A*B, full 32-bit unsigned product.
  - 011 DIV: [15:0] = A/B, [31:16] = A%B. If B=0: quotient 16'hFFFF, remainder A.
  - 100 INC: [16:0] = A+1; bit 16 = carry (set only when A=16'hFFFF).
  - 101 DEC: [15:0] = A-1 mod 2^16; bit 16 = borrow (set only when A=0).
  - 110 NEG: [15:0] = two's complement of A (0 maps to 0, 16'h8000 maps to 16'h8000). Bits [31:16] = 0.
  - 111 CMP: bit 0 = (A==B), bit 1 = (A<B), bit 2 = (A>B). Exactly one of the three is set; bits [31:3] = 0.
- Logic unit uses opcode[1:0] only; opcode[2] is ignored. Result in [15:0], [31:16] = 0.
  - 00 AND: A&B.
  - 01 OR: A|B.
  - 10 XOR: A^B.
  - 11 NOT: ~A; B is ignored.
- X/Z on inputs is not required to be handled; no internal state besides the output register.

Optional Feature:
- Macro ALU_DIV_EN.
- Defined: arithmetic opcode 011 implements DIV exactly as specified above.
- Undefined: no divider logic is synthesized, and opcode 011 produces packed_out = 0. All other opcodes are unchanged.

Test Plan:
- Reset and latency:
  - Hold rst=1 for 2 edges with any input; packed_out = 0.
  - Release rst, apply sel=00_000, packed_in=32'h0001_FFFF. After the next edge, packed_out = 32'h0001_0000 (sum 0, carry 1).
  - Output did not change before that edge.
- Arithmetic sweep:
  - sel=00_001, A=3, B=5 -> 32'h0001_FFFE.
  - sel=00_010, A=B=16'hFFFF -> 32'hFFFE_0001.
  - sel=00_110, A=1 -> 32'h0000_FFFF.
  - sel=00_111, A=7, B=9 -> 32'h0000_0002.
- Division (ALU_DIV_EN defined, then undefined):
  - A=100, B=7 -> 32'h0002_000E.
  - A=5, B=0 -> 32'h0005_FFFF.
  - Without the macro, both -> 0.
- Logic:
  - A=16'hF0F0, B=16'h0FF0.
  - sel=01_000 -> 32'h0000_00F0; 01_001 -> 32'h0000_FFF0; 01_010 -> 32'h0000_FF00; 01_011 -> 32'h0000_0F0F.
  - sel=01_100 gives the same result as 01_000.
- Degenerate mux: sel=10_xxx and 11_xxx with any packed_in -> packed_out = 0.
- Back-to-back and reset mid-stream:
  - Change sel/operands every cycle; each result appears exactly one edge later.
  - Assert rst=1 for one edge mid-stream; packed_out = 0 on that edge, then resumes with the current inputs.
